// File: rtl/lif_pkg.sv
// Shared types and default constants for the time-multiplexed LIF neuron scheduler.
package lif_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        UPDATE,
        WRBACK,
        DONE
    } state_t;

    typedef logic [7:0] membrane_t;

    localparam int DEF_THRESHOLD  = 200;
    localparam int DEF_LEAK_SHIFT = 1;
    localparam int DEF_REFRAC     = 2;

endpackage

// File: rtl/lif_update.sv
// Combinational leak/integrate/saturate/compare step for one neuron.
module lif_update
    import lif_pkg::*;
#(
    parameter int THRESHOLD  = DEF_THRESHOLD,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
    input  membrane_t  membrane,
    input  logic [7:0] cur,
    input  logic       refrac_zero,
    output membrane_t  next,
    output logic       spike
);

    logic [9:0] sum;

    // The leak never exceeds the membrane, so the 10-bit sum cannot underflow.
    always_comb begin
        sum   = {2'b00, membrane} - {2'b00, membrane >> LEAK_SHIFT} + {2'b00, cur};
        next  = (sum > 10'd255) ? 8'hFF : sum[7:0];
        spike = refrac_zero && ({2'b00, next} >= 10'(THRESHOLD));
    end

endmodule

// File: rtl/lif_scheduler.sv
// Sweeps N_NEUR virtual LIF neurons through one shared update datapath,
// three cycles per neuron, and publishes the spike vector at the end of a sweep.
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEUR     = 4,
    parameter int THRESHOLD  = DEF_THRESHOLD,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int REFRAC     = DEF_REFRAC
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick,
    input  logic [8*N_NEUR-1:0]       current,
    input  logic [$clog2(N_NEUR)-1:0] state_sel,
    output logic [7:0]                state_out,
    output logic [N_NEUR-1:0]         spike_vec,
    output logic                      spike_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam int IW = $clog2(N_NEUR);
    localparam logic [IW-1:0] LAST = IW'(N_NEUR - 1);

    state_t            state, state_nx;
    logic [IW-1:0]     index;
    membrane_t         mem_file [N_NEUR];
    logic [7:0]        ref_file [N_NEUR];
    logic [7:0]        cur_q, ref_q;
    membrane_t         mem_q, next_q;
    logic              spike_q;
    logic [N_NEUR-1:0] pending, pending_nx;
    membrane_t         upd_next;
    logic              upd_spike;

    lif_update #(
        .THRESHOLD  (THRESHOLD),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_update (
        .membrane    (mem_q),
        .cur         (cur_q),
        .refrac_zero (ref_q == 8'd0),
        .next        (upd_next),
        .spike       (upd_spike)
    );

    always_comb begin
        state_nx    = state;
        busy        = (state != IDLE);
        spike_valid = (state == DONE);
        pending_nx  = pending;
        pending_nx[index] = spike_q;
        case (state)
            IDLE:    if (tick) state_nx = READ;
            READ:    state_nx = UPDATE;
            UPDATE:  state_nx = WRBACK;
            WRBACK:  state_nx = (index == LAST) ? DONE : READ;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // spike_vec is loaded on the edge entering DONE so it is valid alongside spike_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            index     <= '0;
            cur_q     <= '0;
            mem_q     <= '0;
            ref_q     <= '0;
            next_q    <= '0;
            spike_q   <= 1'b0;
            pending   <= '0;
            spike_vec <= '0;
            overrun   <= 1'b0;
            for (int i = 0; i < N_NEUR; i++) begin
                mem_file[i] <= '0;
                ref_file[i] <= '0;
            end
        end else begin
            state <= state_nx;
            if (tick && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (tick) begin
                        index   <= '0;
                        pending <= '0;
                    end
                end
                READ: begin
                    cur_q <= current[8*index +: 8];
                    mem_q <= mem_file[index];
                    ref_q <= ref_file[index];
                end
                UPDATE: begin
                    next_q  <= upd_next;
                    spike_q <= upd_spike;
                end
                WRBACK: begin
                    pending <= pending_nx;
                    if (spike_q) begin
                        mem_file[index] <= '0;
                        ref_file[index] <= 8'(REFRAC);
                    end else if (ref_q != 8'd0) begin
                        mem_file[index] <= '0;
                        ref_file[index] <= ref_q - 8'd1;
                    end else begin
                        mem_file[index] <= next_q;
                    end
                    if (index == LAST) spike_vec <= pending_nx;
                    else               index     <= index + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state_out = mem_file[state_sel];

endmodule

// File: doc/lif_scheduler.md
LIF_SCHEDULER -- requirements
Module: lif_scheduler

Interface
REQ-001 Parameter N_NEUR, default 4, number of virtual neurons sharing one LIF update datapath (power of two, 2..8).
REQ-002 Parameter THRESHOLD, default 200, spike threshold on the 8-bit membrane value.
REQ-003 Parameter LEAK_SHIFT, default 1, leak equals membrane >> LEAK_SHIFT per update.
REQ-004 Parameter REFRAC, default 2, number of sweeps a neuron is held after it spikes.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 tick  in  1  one-cycle pulse that starts a sweep over all neurons.
REQ-008 current  in  8*N_NEUR  per-neuron input current, neuron i at bits [8i+7:8i], unsigned.
REQ-009 state_sel  in  log2(N_NEUR)  selects the neuron shown on state_out.
REQ-010 state_out  out  8  membrane of neuron state_sel, combinational read of the state file.
REQ-011 spike_vec  out  N_NEUR  spike bits from the last completed sweep, registered.
REQ-012 spike_valid  out  1  one-cycle pulse when spike_vec is updated.
REQ-013 busy  out  1  high while a sweep is in progress, i.e. the FSM is not in IDLE.
REQ-014 overrun  out  1  sticky flag, set when tick arrives while busy.

Function
REQ-015 FSM states: IDLE, READ, UPDATE, WRBACK, DONE.
REQ-016 IDLE: tick=1 -> READ with index=0; tick=0 -> stay in IDLE.
REQ-017 READ: latch current[index], membrane[index] and refrac[index] into datapath registers -> UPDATE.
REQ-018 UPDATE: compute next = m - (m >> LEAK_SHIFT) + cur in 10 bits, saturate to 255, register the result and the spike decision -> WRBACK.
REQ-019 Spike decision: spike when the saturated next value is >= THRESHOLD and refrac is 0.
REQ-020 WRBACK on spike: membrane := 0, refrac := REFRAC, pending spike bit[index] := 1.
REQ-021 WRBACK with refrac > 0: membrane := 0, current ignored, refrac decremented by 1, pending bit := 0.
REQ-022 WRBACK otherwise: membrane := next, pending bit := 0.
REQ-023 WRBACK exit: index == N_NEUR-1 -> DONE; otherwise index += 1 -> READ.
REQ-024 DONE: spike_vec := pending bits, spike_valid=1 for this single cycle -> IDLE.
REQ-025 Latency: 3 cycles per neuron; spike_valid is high in the cycle beginning 3*N_NEUR edges after the edge that samples tick (12 for N_NEUR=4).
REQ-026 tick while busy (including DONE): ignored, overrun := 1; the sweep in progress is unaffected.
REQ-027 tick in the IDLE cycle that immediately follows DONE: accepted normally.
REQ-028 current may change during a sweep; each neuron uses the value latched in its own READ cycle.
REQ-029 state_out reflects a WRBACK write in the cycle after the write edge.

Reset
REQ-030 rst_n=0 at a clock edge: FSM -> IDLE, index=0, all membranes and refrac counters -> 0, spike_vec=0, spike_valid=0, overrun=0, busy=0.
REQ-031 Reset mid-sweep: the sweep is aborted with no spike_valid and no partial spike_vec update.
REQ-032 The first tick after rst_n returns to 1 is accepted.

Structure
REQ-033 A shared package lif_pkg holds the FSM state enum, the 8-bit membrane type and the default THRESHOLD, LEAK_SHIFT and REFRAC constants.
REQ-034 The leak/integrate/saturate/compare arithmetic is a sub-module, lif_update (combinational; its result is registered by lif_scheduler in UPDATE).
REQ-035 The membrane and refrac files are flop arrays inside lif_scheduler; no SRAM is used.

Verification
REQ-036 Reset, then current[0]=150, others 0, two ticks: sweep 1 gives state_out(0)=150 with spike_vec=0; sweep 2 gives spike_vec=0001 and state_out(0)=0.
REQ-037 After the spike in REQ-036, two more ticks with current 150: spike_vec=0000 and membrane 0 both sweeps; third sweep gives state_out(0)=150.
REQ-038 Saturation: neuron 1 at 150, current[1]=255, one tick: computed 330 saturates to 255, spike_vec bit1=1, membrane 0.
REQ-039 Timing and overrun: tick, then a second tick 5 cycles later: spike_valid exactly 12 cycles after the first tick, overrun=1, only one spike_valid pulse.
REQ-040 Assert rst_n=0 at cycle 6 of a sweep: no spike_valid; after release, all state_out reads are 0 and overrun=0.
REQ-041 Leak: current[2]=100 constant: membrane sequence 100, 150, 175, 188, 194, 197, 199, 200; spike on sweep 8.
